// File: rtl/xmult_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
// Holds the FSM state encoding and the default operand/counter widths.
// Imported by xmult_core and xmult_shift_add.
package xmult_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  // Must satisfy 2**CNT_WIDTH_DEF > DATA_WIDTH_DEF.
  localparam int CNT_WIDTH_DEF  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xmult_shift_add.sv
// One combinational shift-add step of an unsigned multiplier.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register the result.
module xmult_shift_add
  import xmult_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   mcand,
  input  logic                    mplier_lsb,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  // Upper-half add is W+1 bits wide; its carry lands in the MSB of acc_next
  // after the right shift, so {carry, acc} shifted is a single vector here.
  logic [W:0] sum;

  // Conditional add of the multiplicand followed by a one-bit right shift.
  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (mplier_lsb ? {1'b0, mcand} : {(W+1){1'b0}});
    acc_next = (2*W)'({sum, acc[W-1:0]} >> 1);
  end

endmodule

// File: rtl/xmult_core.sv
// Iterative DATA_WIDTH x DATA_WIDTH multiplier, signed or unsigned operands.
// Latency: start sampled at edge 0 -> result and done valid after edge DATA_WIDTH+1.
// Backpressure: none beyond busy; start while busy is ignored.
module xmult_core
  import xmult_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  clr,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic                  done_pulse,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi
);

  localparam int W = DATA_WIDTH;

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         mcand;
  logic [W-1:0]         mplier;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       acc_step;
  logic [2*W-1:0]       prod_fixed;
  logic                 neg;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last_iter;

  // Magnitude in W bits; the most-negative value maps to itself, which is
  // correct when read back as unsigned.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sm);
    return (sm && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  xmult_shift_add #(.DATA_WIDTH(W)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_step)
  );

  // Signals derived from the current state and counter.
  always_comb begin
    last_iter  = (cnt == CNT_WIDTH'(W - 1));
    prod_fixed = neg ? (~acc + 1'b1) : acc;
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start takes priority over clr when both are present.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last_iter) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
        end else if (clr) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latching, iteration, sign fix-up and status flags.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      result_lo  <= '0;
      result_hi  <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand  <= magnitude(op_a, signed_mode);
            mplier <= magnitude(op_b, signed_mode);
            neg    <= signed_mode & (op_a[W-1] ^ op_b[W-1]);
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
          end else if (clr && (state == S_DONE)) begin
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
          end
        end
        S_RUN: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_FIN: begin
          result_lo  <= prod_fixed[W-1:0];
          result_hi  <= prod_fixed[2*W-1:W];
          busy       <= 1'b0;
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
